cam_multiport_regfile: RTL and testbench

Parametrised register file with multiple read ports, one write port and a masked CAM search port. Each entry has a valid bit, which the CAM and a free-entry finder use. The block replaces the fixed single-read tri-port regfile in tag arrays, MSHRs and store queues. Reads and searches are registered with 1-cycle latency. Write-to-read bypass is optional.

---
 rtl/cam_multiport_regfile.sv | 127 ++++++++++++
 tb/tb_cam_multiport_regfile.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cam_multiport_regfile.sv
// Multi-read, single-write register file with per-entry valid bits, a masked CAM
// search port and a lowest-free-entry finder. All outputs are registered.
module cam_multiport_regfile #(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 8,
  parameter int NUMBER_ENTRY              = 8,
  parameter int NUM_READ_PORT             = 2,
  parameter int BYPASS_EN                 = 0,
  localparam int ADDR_W                   = $clog2(NUMBER_ENTRY)
) (
  input  logic                                           clk_in,
  input  logic                                           reset_in,
  input  logic                                           write_en_in,
  input  logic [ADDR_W-1:0]                              write_addr_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]           write_entry_in,
  input  logic                                           invalidate_en_in,
  input  logic [NUMBER_ENTRY-1:0]                        invalidate_mask_in,
  input  logic [NUM_READ_PORT-1:0]                       read_en_in,
  input  logic [NUM_READ_PORT*ADDR_W-1:0]                read_addr_in,
  output logic [NUM_READ_PORT*SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_out,
  output logic [NUM_READ_PORT-1:0]                       read_valid_out,
  input  logic                                           cam_en_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]           cam_entry_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]           cam_mask_in,
  output logic [NUMBER_ENTRY-1:0]                        cam_result_decoded_out,
  output logic                                           cam_hit_out,
  output logic [ADDR_W-1:0]                              cam_hit_index_out,
  output logic                                           free_valid_out,
  output logic [ADDR_W-1:0]                              free_index_out
);
  localparam int DW = SINGLE_ENTRY_SIZE_IN_BITS;

  logic [DW-1:0]                         r_data [NUMBER_ENTRY];
  logic [NUMBER_ENTRY-1:0]               r_valid;
  logic [NUM_READ_PORT-1:0][DW-1:0]      r_rd_data;
  logic [NUM_READ_PORT-1:0]              r_rd_vld;
  logic [NUMBER_ENTRY-1:0]               r_cam_hit_vec;
  logic                                  r_cam_hit;
  logic [ADDR_W-1:0]                     r_cam_idx;
  logic                                  r_free_vld;
  logic [ADDR_W-1:0]                     r_free_idx;

  logic                                  w_wr_ok;
  logic [NUMBER_ENTRY-1:0]               w_valid_nxt;
  logic [NUM_READ_PORT-1:0][DW-1:0]      w_rd_data;
  logic [NUM_READ_PORT-1:0]              w_rd_vld;
  logic [NUMBER_ENTRY-1:0]               w_hit;
  logic [ADDR_W-1:0]                     w_hit_idx;
  logic [ADDR_W-1:0]                     w_free_idx;

  // Writes beyond the last entry are dropped (NUMBER_ENTRY need not be a power of two).
  assign w_wr_ok = write_en_in && (32'(write_addr_in) < NUMBER_ENTRY);

  // Write beats invalidate on the same entry.
  always_comb begin
    w_valid_nxt = r_valid;
    if (invalidate_en_in) w_valid_nxt = w_valid_nxt & ~invalidate_mask_in;
    for (int i = 0; i < NUMBER_ENTRY; i++)
      if (w_wr_ok && write_addr_in == ADDR_W'(i)) w_valid_nxt[i] = 1'b1;
  end

  // Out-of-range read indices match no entry and so read as zero.
  always_comb begin
    w_rd_data = '0;
    w_rd_vld  = '0;
    for (int p = 0; p < NUM_READ_PORT; p++) begin
      for (int i = 0; i < NUMBER_ENTRY; i++) begin
        if (read_addr_in[p*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
          w_rd_data[p] = r_data[i];
          w_rd_vld[p]  = r_valid[i];
        end
      end
      if (BYPASS_EN != 0 && w_wr_ok && read_addr_in[p*ADDR_W +: ADDR_W] == write_addr_in) begin
        w_rd_data[p] = write_entry_in;
        w_rd_vld[p]  = 1'b1;
      end
    end
  end

  // CAM sees pre-write state; priority encoders scan high-to-low so the lowest index wins.
  always_comb begin
    w_hit      = '0;
    w_hit_idx  = '0;
    w_free_idx = '0;
    for (int i = 0; i < NUMBER_ENTRY; i++)
      w_hit[i] = cam_en_in && r_valid[i] && (((r_data[i] ^ cam_entry_in) & cam_mask_in) == '0);
    for (int i = NUMBER_ENTRY-1; i >= 0; i--) begin
      if (w_hit[i])        w_hit_idx  = ADDR_W'(i);
      if (!w_valid_nxt[i]) w_free_idx = ADDR_W'(i);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      for (int i = 0; i < NUMBER_ENTRY; i++) r_data[i] <= '0;
      r_valid       <= '0;
      r_rd_data     <= '0;
      r_rd_vld      <= '0;
      r_cam_hit_vec <= '0;
      r_cam_hit     <= 1'b0;
      r_cam_idx     <= '0;
      r_free_vld    <= 1'b0;
      r_free_idx    <= '0;
    end else begin
      for (int i = 0; i < NUMBER_ENTRY; i++)
        if (w_wr_ok && write_addr_in == ADDR_W'(i)) r_data[i] <= write_entry_in;
      r_valid <= w_valid_nxt;
      for (int p = 0; p < NUM_READ_PORT; p++) begin
        r_rd_data[p] <= read_en_in[p] ? w_rd_data[p] : '0;
        r_rd_vld[p]  <= read_en_in[p] & w_rd_vld[p];
      end
      r_cam_hit_vec <= w_hit;
      r_cam_hit     <= |w_hit;
      r_cam_idx     <= w_hit_idx;
      r_free_vld    <= ~&w_valid_nxt;
      r_free_idx    <= w_free_idx;
    end
  end

  assign read_entry_out         = r_rd_data;
  assign read_valid_out         = r_rd_vld;
  assign cam_result_decoded_out = r_cam_hit_vec;
  assign cam_hit_out            = r_cam_hit;
  assign cam_hit_index_out      = r_cam_idx;
  assign free_valid_out         = r_free_vld;
  assign free_index_out         = r_free_idx;

endmodule

// File: tb/tb_cam_multiport_regfile.sv
// Directed bench: default instance, a bypass instance and a 6-entry instance share stimulus.
module tb_cam_multiport_regfile;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [2:0]  wa;
  logic [7:0]  wd;
  logic        inv_en;
  logic [7:0]  inv_mask;
  logic [1:0]  re;
  logic [5:0]  ra;
  logic        cam_en;
  logic [7:0]  cam_key, cam_mask;

  logic [15:0] a_rd, b_rd, c_rd;
  logic [1:0]  a_rv, b_rv, c_rv;
  logic [7:0]  a_res, b_res;
  logic [5:0]  c_res;
  logic        a_hit, b_hit, c_hit, a_fv, b_fv, c_fv;
  logic [2:0]  a_idx, b_idx, c_idx, a_fi, b_fi, c_fi;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cam_multiport_regfile u_a (
    .clk_in(clk), .reset_in(rst_n), .write_en_in(we), .write_addr_in(wa), .write_entry_in(wd),
    .invalidate_en_in(inv_en), .invalidate_mask_in(inv_mask), .read_en_in(re), .read_addr_in(ra),
    .read_entry_out(a_rd), .read_valid_out(a_rv), .cam_en_in(cam_en), .cam_entry_in(cam_key),
    .cam_mask_in(cam_mask), .cam_result_decoded_out(a_res), .cam_hit_out(a_hit),
    .cam_hit_index_out(a_idx), .free_valid_out(a_fv), .free_index_out(a_fi));

  cam_multiport_regfile #(.BYPASS_EN(1)) u_b (
    .clk_in(clk), .reset_in(rst_n), .write_en_in(we), .write_addr_in(wa), .write_entry_in(wd),
    .invalidate_en_in(inv_en), .invalidate_mask_in(inv_mask), .read_en_in(re), .read_addr_in(ra),
    .read_entry_out(b_rd), .read_valid_out(b_rv), .cam_en_in(cam_en), .cam_entry_in(cam_key),
    .cam_mask_in(cam_mask), .cam_result_decoded_out(b_res), .cam_hit_out(b_hit),
    .cam_hit_index_out(b_idx), .free_valid_out(b_fv), .free_index_out(b_fi));

  cam_multiport_regfile #(.NUMBER_ENTRY(6)) u_c (
    .clk_in(clk), .reset_in(rst_n), .write_en_in(we), .write_addr_in(wa), .write_entry_in(wd),
    .invalidate_en_in(inv_en), .invalidate_mask_in(inv_mask[5:0]), .read_en_in(re), .read_addr_in(ra),
    .read_entry_out(c_rd), .read_valid_out(c_rv), .cam_en_in(cam_en), .cam_entry_in(cam_key),
    .cam_mask_in(cam_mask), .cam_result_decoded_out(c_res), .cam_hit_out(c_hit),
    .cam_hit_index_out(c_idx), .free_valid_out(c_fv), .free_index_out(c_fi));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; wa = 0; wd = 0; inv_en = 0; inv_mask = 0;
    re = 0; ra = 0; cam_en = 0; cam_key = 0; cam_mask = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    idle(); we = 1; wa = a; wd = d;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle(); rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    tick(); tick();
    chk("rst_rd", a_rd, 0);
    chk("rst_rv", a_rv, 0);
    chk("rst_res", a_res, 0);
    chk("rst_fv", a_fv, 0);
    chk("rst_fi", a_fi, 0);
    rst_n = 1;

    // reset mid-traffic
    wr(3, 8'hAA);
    rst_n = 0; we = 1; wa = 3; wd = 8'h77; re = 2'b11; ra = {3'd3, 3'd3}; cam_en = 1;
    tick();
    chk("mid_rst_rd", a_rd, 0);
    chk("mid_rst_rv", a_rv, 0);
    chk("mid_rst_hit", a_hit, 0);
    chk("mid_rst_res", a_res, 0);
    chk("mid_rst_fv", a_fv, 0);
    rst_n = 1; idle(); re = 2'b01; ra = {3'd0, 3'd3};
    tick();
    chk("post_rst_rd3", a_rd[7:0], 8'h00);
    chk("post_rst_rv3", a_rv[0], 0);
    chk("post_rst_fv", a_fv, 1);
    chk("post_rst_fi", a_fi, 0);

    // dual read
    wr(1, 8'h11);
    wr(6, 8'h22);
    re = 2'b11; ra = {3'd6, 3'd1};
    tick();
    chk("dual_rd", a_rd, 16'h2211);
    chk("dual_rv", a_rv, 2'b11);
    ra = {3'd6, 3'd6};
    tick();
    chk("same_idx_rd", a_rd, 16'h2222);
    chk("same_idx_rv", a_rv, 2'b11);
    re = 2'b10; ra = {3'd1, 3'd1};
    tick();
    chk("rd_en_off_p0", a_rd[7:0], 8'h00);
    chk("rd_en_off_v0", a_rv, 2'b10);

    // read/write collision
    wr(2, 8'h33);
    we = 1; wa = 2; wd = 8'h5C; re = 2'b01; ra = {3'd0, 3'd2};
    tick();
    chk("coll_nobyp_rd", a_rd[7:0], 8'h33);
    chk("coll_nobyp_rv", a_rv[0], 1);
    chk("coll_byp_rd", b_rd[7:0], 8'h5C);
    chk("coll_byp_rv", b_rv[0], 1);
    we = 1; wa = 7; wd = 8'h77; re = 2'b01; ra = {3'd0, 3'd7};
    tick();
    chk("coll_inv_nobyp_rd", a_rd[7:0], 8'h00);
    chk("coll_inv_nobyp_rv", a_rv[0], 0);
    chk("coll_inv_byp_rd", b_rd[7:0], 8'h77);
    chk("coll_inv_byp_rv", b_rv[0], 1);
    idle();

    // masked CAM
    do_reset();
    wr(0, 8'hF1);
    wr(4, 8'h31);
    wr(5, 8'h31);
    inv_en = 1; inv_mask = 8'h20;
    tick();
    idle(); cam_en = 1; cam_key = 8'h01; cam_mask = 8'h0F;
    tick();
    chk("cam_msk_res", a_res, 8'h11);
    chk("cam_msk_hit", a_hit, 1);
    chk("cam_msk_idx", a_idx, 0);
    cam_key = 8'h31; cam_mask = 8'hFF;
    tick();
    chk("cam_full_res", a_res, 8'h10);
    chk("cam_full_idx", a_idx, 4);
    cam_key = 8'h5A; cam_mask = 8'h00;
    tick();
    chk("cam_nomask_res", a_res, 8'h11);
    cam_key = 8'h02; cam_mask = 8'h0F;
    tick();
    chk("cam_miss_res", a_res, 0);
    chk("cam_miss_hit", a_hit, 0);
    chk("cam_miss_idx", a_idx, 0);
    cam_key = 8'h01; cam_mask = 8'hFF; we = 1; wa = 1; wd = 8'h01;
    tick();
    chk("cam_prewrite_res", a_res, 0);
    we = 0;
    tick();
    chk("cam_postwrite_res", a_res, 8'h02);
    chk("cam_postwrite_idx", a_idx, 1);
    cam_en = 0;
    tick();
    chk("cam_off_res", a_res, 0);
    chk("cam_off_hit", a_hit, 0);

    // free finder / full
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr(3'(i), 8'(8'h40 + i));
      if (i == 6) begin
        chk("free_one_left_fv", a_fv, 1);
        chk("free_one_left_fi", a_fi, 7);
      end
    end
    chk("full_fv", a_fv, 0);
    chk("full_fi", a_fi, 0);
    inv_en = 1; inv_mask = 8'h24;
    tick();
    chk("inv2_fv", a_fv, 1);
    chk("inv2_fi", a_fi, 2);
    we = 1; wa = 2; wd = 8'h99; inv_en = 1; inv_mask = 8'h04;
    tick();
    chk("wr_beats_inv_fv", a_fv, 1);
    chk("wr_beats_inv_fi", a_fi, 5);
    idle(); re = 2'b01; ra = {3'd0, 3'd2};
    tick();
    chk("wr_beats_inv_rd", a_rd[7:0], 8'h99);
    chk("wr_beats_inv_rv", a_rv[0], 1);
    idle();

    // out-of-range on the 6-entry instance
    do_reset();
    wr(5, 8'h55);
    we = 1; wa = 7; wd = 8'hEE; re = 2'b01; ra = {3'd0, 3'd7};
    tick();
    chk("oor_rd", c_rd[7:0], 8'h00);
    chk("oor_rv", c_rv[0], 0);
    chk("oor_fi", c_fi, 0);
    idle(); cam_en = 1; cam_key = 8'hEE; cam_mask = 8'hFF;
    tick();
    chk("oor_cam_miss", c_res, 0);
    cam_mask = 8'h00;
    tick();
    chk("oor_cam_all", c_res, 6'b100000);
    chk("oor_cam_idx", c_idx, 5);
    idle(); re = 2'b01; ra = {3'd0, 3'd5};
    tick();
    chk("oor_rd5", c_rd[7:0], 8'h55);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
